// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// The Count/Compare timer is built only when CP0_TIMER_EN is defined; otherwise Count/Compare read 0.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE = 32'h004c0102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] STATUS_RST   = 32'h10000000;
    localparam logic [31:0] CONFIG_VALUE = 32'h00008000;
    // Software may only touch IV, WP and IP[1:0] in Cause.
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C00300;

    localparam logic [31:0] EXC_INT      = 32'h00000001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h00000008;
    localparam logic [31:0] EXC_INV      = 32'h0000000a;
    localparam logic [31:0] EXC_TRAP     = 32'h0000000d;
    localparam logic [31:0] EXC_OV       = 32'h0000000c;
    localparam logic [31:0] EXC_ERET     = 32'h0000000e;

    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic [31:0] status_reg, status_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;
    logic        timer_reg, timer_next;

    logic        exc_take;
    logic [4:0]  exc_code;
    logic        eret;
    logic        wr_status, wr_cause, wr_epc;

    assign wr_status = we_i && (waddr_i == ADDR_STATUS);
    assign wr_cause  = we_i && (waddr_i == ADDR_CAUSE);
    assign wr_epc    = we_i && (waddr_i == ADDR_EPC);
    assign eret      = (excepttype_i == EXC_ERET);

    always_comb begin
        exc_take = 1'b1;
        exc_code = 5'h00;
        case (excepttype_i)
            EXC_INT:     exc_code = 5'h00;
            EXC_SYSCALL: exc_code = 5'h08;
            EXC_INV:     exc_code = 5'h0a;
            EXC_TRAP:    exc_code = 5'h0d;
            EXC_OV:      exc_code = 5'h0c;
            default:     exc_take = 1'b0;
        endcase
    end

`ifdef CP0_TIMER_EN
    logic wr_count, wr_compare;
    assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
    assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);

    // Match is taken on the registered values, so the interrupt lags the match by one cycle.
    always_comb begin
        count_next   = wr_count ? wdata_i : count_reg + 32'd1;
        compare_next = wr_compare ? wdata_i : compare_reg;
        timer_next   = timer_reg;
        if (wr_compare) begin
            timer_next = 1'b0;
        end else if ((compare_reg != 32'd0) && (count_reg == compare_reg)) begin
            timer_next = 1'b1;
        end
    end
`else
    always_comb begin
        count_next   = 32'd0;
        compare_next = 32'd0;
        timer_next   = 1'b0;
    end
`endif

    // Software write first, then exception effects override the fields they own.
    always_comb begin
        status_next = status_reg;
        cause_next  = cause_reg;
        epc_next    = epc_reg;
        if (wr_status) begin
            status_next = wdata_i;
        end
        if (wr_cause) begin
            cause_next = (cause_reg & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
        end
        if (wr_epc) begin
            epc_next = wdata_i;
        end
        cause_next[15:10] = int_i;
        if (exc_take) begin
            if (!status_reg[1]) begin
                epc_next      = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                  : current_inst_addr_i;
                cause_next[31] = is_in_delayslot_i;
            end
            status_next[1]   = 1'b1;
            cause_next[6:2]  = exc_code;
        end else if (eret) begin
            status_next[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
            status_reg  <= STATUS_RST;
            cause_reg   <= 32'd0;
            epc_reg     <= 32'd0;
            timer_reg   <= 1'b0;
        end else begin
            count_reg   <= count_next;
            compare_reg <= compare_next;
            status_reg  <= status_next;
            cause_reg   <= cause_next;
            epc_reg     <= epc_next;
            timer_reg   <= timer_next;
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (rst) begin
            case (raddr_i)
                ADDR_COUNT:   data_o = count_reg;
                ADDR_COMPARE: data_o = compare_reg;
                ADDR_STATUS:  data_o = status_reg;
                ADDR_CAUSE:   data_o = cause_reg;
                ADDR_EPC:     data_o = epc_reg;
                ADDR_PRID:    data_o = PRID_VALUE;
                ADDR_CONFIG:  data_o = CONFIG_VALUE;
                default:      data_o = 32'd0;
            endcase
        end
    end

    assign count_o     = count_reg;
    assign compare_o   = compare_reg;
    assign status_o    = status_reg;
    assign cause_o     = cause_reg;
    assign epc_o       = epc_reg;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_reg;

endmodule
